// File: rtl/readout_sequencer.sv
// Event-level readout controller: arms a bank of digitizer channels, broadcasts the trigger,
// then reads each enabled channel in turn into one framed stream (header word + samples).
module readout_sequencer #(
    parameter int NCHAN      = 4,
    parameter int SIZE       = 8,
    parameter int WIDTH      = 12,
    parameter int RD_LATENCY = 2
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   arm,
    input  logic                   trigger,
    input  logic [NCHAN-1:0]       chan_mask,
    input  logic [SIZE-1:0]        howmany,
    input  logic [SIZE-1:0]        offset,
    input  logic [SIZE-1:0]        holdoff,
    input  logic                   out_ready,
    input  logic [NCHAN*WIDTH-1:0] ch_dout,
    output logic                   ch_davail,
    output logic                   ch_trigger,
    output logic [NCHAN-1:0]       ch_rd_request,
    output logic [SIZE-1:0]        ch_howmany,
    output logic [SIZE-1:0]        ch_offset,
    output logic [WIDTH-1:0]       dout,
    output logic                   dout_valid,
    output logic                   dout_last,
    output logic                   busy,
    output logic                   missed_trig,
    output logic [15:0]            evt_count,
    output logic [2:0]             dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_HOLDOFF, S_SCAN, S_HEADER, S_REQ, S_STREAM, S_DONE
    } state_t;

    localparam int IDX_W = $clog2(NCHAN + 1);
    localparam int LAT_W = $clog2(RD_LATENCY + 1);

    state_t            state;
    logic [NCHAN-1:0]  mask_q;
    logic [SIZE-1:0]   hold_cnt;
    logic [SIZE-1:0]   word_cnt;
    logic [IDX_W-1:0]  idx;
    logic [LAT_W-1:0]  lat_cnt;

    logic              found;
    logic [IDX_W-1:0]  next_idx;
    logic              more_after;
    logic [WIDTH-1:0]  sel_data;
    logic [WIDTH-1:0]  header_word;

    assign dbg_state = state;

    // Lowest enabled channel at or above idx, whether any enabled channel lies beyond idx,
    // and the data bus of the channel currently being streamed.
    always_comb begin
        found      = 1'b0;
        next_idx   = '0;
        more_after = 1'b0;
        sel_data   = '0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (mask_q[i] && (i >= int'(idx))) begin
                found    = 1'b1;
                next_idx = IDX_W'(i);
            end
            if (mask_q[i] && (i > int'(idx)))
                more_after = 1'b1;
            if (int'(idx) == i)
                sel_data = ch_dout[i*WIDTH +: WIDTH];
        end
        header_word        = '0;
        header_word[11:0]  = {4'hA, 4'(idx), evt_count[3:0]};
    end

    // Handshake: out_ready is sampled only while a header is pending; a channel block, once
    // requested, streams without stalling and dout_valid marks every word it produces.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= S_IDLE;
            mask_q        <= '0;
            hold_cnt      <= '0;
            word_cnt      <= '0;
            idx           <= '0;
            lat_cnt       <= '0;
            ch_davail     <= 1'b0;
            ch_trigger    <= 1'b0;
            ch_rd_request <= '0;
            ch_howmany    <= '0;
            ch_offset     <= '0;
            dout          <= '0;
            dout_valid    <= 1'b0;
            dout_last     <= 1'b0;
            busy          <= 1'b0;
            missed_trig   <= 1'b0;
            evt_count     <= '0;
        end else begin
            ch_trigger    <= 1'b0;
            ch_rd_request <= '0;
            dout_valid    <= 1'b0;
            dout_last     <= 1'b0;
            missed_trig   <= trigger && busy;
            case (state)
                S_IDLE: begin
                    if (arm) begin
                        state     <= S_ARMED;
                        ch_davail <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (trigger) begin
                        state      <= S_HOLDOFF;
                        busy       <= 1'b1;
                        ch_trigger <= 1'b1;
                        mask_q     <= chan_mask;
                        ch_howmany <= howmany;
                        ch_offset  <= offset;
                        hold_cnt   <= holdoff;
                        idx        <= '0;
                    end
                end
                S_HOLDOFF: begin
                    if (hold_cnt == '0) begin
                        state     <= S_SCAN;
                        ch_davail <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                S_SCAN: begin
                    if (found && (ch_howmany != '0)) begin
                        idx   <= next_idx;
                        state <= S_HEADER;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_HEADER: begin
                    if (out_ready) begin
                        dout          <= header_word;
                        dout_valid    <= 1'b1;
                        ch_rd_request <= NCHAN'(1) << idx;
                        state         <= S_REQ;
                    end
                end
                S_REQ: begin
                    lat_cnt  <= LAT_W'(1);
                    word_cnt <= '0;
                    state    <= S_STREAM;
                end
                S_STREAM: begin
                    if (lat_cnt >= LAT_W'(RD_LATENCY)) begin
                        dout       <= sel_data;
                        dout_valid <= 1'b1;
                        if (word_cnt == ch_howmany - 1'b1) begin
                            dout_last <= !more_after;
                            idx       <= idx + 1'b1;
                            state     <= S_SCAN;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    evt_count <= evt_count + 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/readout_sequencer.md
Name: readout_sequencer

Overview:
Event-level controller for a bank of NCHAN digitizer channels, each built from a ring buffer, a channel state machine and an address controller. It arms the channels and broadcasts the trigger. After a programmable post-trigger holdoff, it reads the enabled channels out one at a time through their read-request inputs. The selected channel's samples are merged into one framed output stream, with a header word before each channel's block.

Parameters:
NCHAN, 4, number of channels sequenced (1..16)
SIZE, 8, width of howmany/offset/holdoff fields
WIDTH, 12, sample and output word width (>= 12)
RD_LATENCY, 2, cycles from ch_rd_request pulse to first valid word on that channel's data bus (>= 1)

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous reset, active-high
arm  in  1  pulse: start acquisition
trigger  in  1  external trigger
chan_mask  in  NCHAN  channel enable, bit i = channel i
howmany  in  SIZE  samples to read per channel
offset  in  SIZE  read start offset relative to trigger
holdoff  in  SIZE  post-trigger cycles before readout
out_ready  in  1  downstream may accept a new channel block
ch_dout  in  NCHAN*WIDTH  channel data, channel i at bits [i*WIDTH +: WIDTH]
ch_davail  out  1  channels acquiring (write enable to channel state machines)
ch_trigger  out  1  one-cycle trigger broadcast
ch_rd_request  out  NCHAN  one-hot, one-cycle read request
ch_howmany  out  SIZE  latched howmany
ch_offset  out  SIZE  latched offset
dout  out  WIDTH  output word
dout_valid  out  1  dout qualifier
dout_last  out  1  final word of event
busy  out  1  high in any state except IDLE/ARMED
missed_trig  out  1  one-cycle pulse: trigger ignored
evt_count  out  16  completed events, wraps at 2^16

Behaviour:
- Reset (async, any time incl. mid-stream): state IDLE; all outputs 0; internal counters and channel index 0. No partial frame is completed after reset releases.
- States: IDLE, ARMED, HOLDOFF, SCAN, HEADER, REQ, STREAM, DONE.
- IDLE: arm=1 -> ARMED. trigger ignored, no missed_trig.
- ARMED: ch_davail=1. trigger=1 -> HOLDOFF. Same cycle: register ch_trigger=1 for exactly one cycle, latch howmany/offset/chan_mask, load holdoff counter. arm ignored.
- HOLDOFF: ch_davail=1. Counter decrements each cycle; at 0 -> SCAN, ch_davail->0. holdoff=0 gives exactly 1 cycle in HOLDOFF.
- SCAN (1 cycle): pick lowest enabled index >= current index. If found -> HEADER; if none, or latched howmany=0 -> DONE. Channel index starts at 0 per event.
- HEADER: wait for out_ready=1 at the cycle start. Then emit one word with dout_valid=1: dout[11:8]=4'hA, [7:4]=channel index, [3:0]=evt_count[3:0], upper bits (WIDTH>12) 0. Next -> REQ.
- REQ (1 cycle): ch_rd_request[i]=1 (only bit i) -> STREAM.
- STREAM: pulse at cycle t. Channel word k is on ch_dout[i] at t+RD_LATENCY+k, k=0..howmany-1. Sequencer registers it; dout_valid=1 at t+RD_LATENCY+1+k. out_ready is ignored inside STREAM (channel data cannot stall). After the last word: index=i+1 -> SCAN.
- dout_last=1 with the last data word of the last enabled channel only.
- DONE (1 cycle): evt_count+1; -> IDLE. A new arm is required for the next event.
- No enabled channels (mask=0 or howmany=0): trigger, holdoff and evt_count increment still occur; no words emitted, no dout_last.
- trigger while in HOLDOFF..DONE: missed_trig pulses 1 cycle; no other effect. trigger in the same cycle as the arm pulse in IDLE: not captured.
- chan_mask/howmany/offset/holdoff changes after latch have no effect until the next trigger.
- dout holds its last value when dout_valid=0. busy is registered with the state.

Test Plan:
- Reset: hold RESET during STREAM for ch2 -> all outputs 0 within 0 cycles (async). After release, state IDLE; arm+trigger runs a clean event starting at ch0.
- Full event: mask=4'b1111, howmany=3, holdoff=5, out_ready=1, RD_LATENCY=2. Expect 16 words = 4x(header + 3 data). Headers 0xA00, 0xA10, 0xA20, 0xA30. dout_last on word 16; evt_count 0->1.
- Sparse mask: mask=4'b1010, howmany=2 -> headers 0xA10 then 0xA30 only. ch_rd_request shows only 4'b0010 then 4'b1000. dout_last on 6th word.
- Backpressure: out_ready=0 for 10 cycles before ch1 header -> no dout_valid and no ch_rd_request for those cycles. Header 0xA10 appears the first cycle out_ready=1 is sampled.
- Latency check: pulse ch_rd_request at t with ch_dout[0]=0x123 at t+2 -> dout=0x123, dout_valid=1 at t+3.
- Edge cases: mask=0 -> no words, evt_count increments. Trigger during HOLDOFF -> missed_trig pulses once. holdoff=0 -> SCAN 2 cycles after the trigger cycle. 65536 events -> evt_count wraps to 0.
